// File: rtl/rv_fetch_unit.sv
// RV32 fetch stage: owns the PC, issues 1-cycle-latency I-MEM reads, queues {instr, pc} toward decode.
// Fetch-to-fq_valid latency 2 cycles; a credit check stalls issue when the queue plus the in-flight read would overflow.
// Optional macro MISALIGN_TRAP_EN: a misaligned redirect enters a sticky FAULT state instead of being aligned.
module rv_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              IMEM_AW     = 6,
    parameter int              FETCH_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [IMEM_AW-1:0]           imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         redir_valid,
    input  logic [XLEN-1:0]              redir_target,
    output logic                         fq_valid,
    input  logic                         fq_ready,
    output logic [31:0]                  fq_instr,
    output logic [XLEN-1:0]              fq_pc,
    output logic [$clog2(FETCH_DEPTH):0] fq_count,
    output logic                         fetch_fault
);
    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FETCH_DEPTH);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    logic [31:0]     instr_mem [FETCH_DEPTH];
    logic [XLEN-1:0] pc_mem    [FETCH_DEPTH];

    logic            active, push, pop, flush, credit_ok;
    logic [CW:0]     occ;

`ifdef MISALIGN_TRAP_EN
    assign active      = (state_q != ST_FAULT);
    assign fetch_fault = (state_q == ST_FAULT);
`else
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = |redir_target[1:0];
    assign active      = 1'b1;
    assign fetch_fault = 1'b0;
`endif

    assign fq_valid  = active && (count_q != '0);
    assign fq_count  = count_q;
    assign imem_addr = imem_req ? fetch_pc_q[IMEM_AW+1:2] : '0;

    // Slots committed by the end of this cycle: queued + response landing now - head leaving now.
    assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(fq_valid && fq_ready);
    assign credit_ok = (occ < DEPTH_W);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = 1'b0;
        imem_req   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end
        if (active && redir_valid) begin
            flush      = 1'b1;
            fetch_pc_d = {redir_target[XLEN-1:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
            if (redir_target[1:0] != 2'b00) begin
                fetch_pc_d = redir_target;
                state_d    = ST_FAULT;
            end
`endif
        end else if (active) begin
            push = inflight_q;
            pop  = fq_valid && fq_ready;
            if (state_q == ST_RUN && credit_ok) begin
                imem_req   = 1'b1;
                inflight_d = 1'b1;
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PW'(1);
                if (pop)  head_q <= head_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= resp_pc_q;
        end
    end

    // In FAULT the raw redirect target is exposed on fq_pc for the trap handler.
    always_comb begin
        fq_instr = '0;
        fq_pc    = '0;
        if (fq_valid) begin
            fq_instr = instr_mem[head_q];
            fq_pc    = pc_mem[head_q];
        end
`ifdef MISALIGN_TRAP_EN
        else if (state_q == ST_FAULT) begin
            fq_pc = fetch_pc_q;
        end
`endif
    end

endmodule
